// File: rtl/collision_predict.sv
// Two-bot collision predictor: integrates both positions over a fixed horizon and reports
// the first step where separation drops below SAFE_DIST, plus the minimum squared separation.
module collision_predict #(
  parameter int unsigned STEPS     = 8,
  parameter int unsigned DT_SHIFT  = 3,
  parameter logic [15:0] SAFE_DIST = 16'h0400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] x1_bin,
  input  logic [15:0] y1_bin,
  input  logic [15:0] vx1_bin,
  input  logic [15:0] vy1_bin,
  input  logic [15:0] x2_bin,
  input  logic [15:0] y2_bin,
  input  logic [15:0] vx2_bin,
  input  logic [15:0] vy2_bin,
  input  logic        read_done,
  output logic        busy,
  output logic        result_valid,
  output logic        collision,
  output logic [3:0]  hit_step,
  output logic [31:0] min_dist_sq,
  output logic        overrun
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [31:0] SafeSq = 32'(SAFE_DIST) * 32'(SAFE_DIST);

  logic [1:0]  state_q, state_d;
  logic        read_done_q;
  logic        rd_edge;

  logic [15:0] p1x_q, p1y_q, v1x_q, v1y_q;
  logic [15:0] p2x_q, p2y_q, v2x_q, v2y_q;
  logic [3:0]  step_q;
  logic [31:0] min_q;
  logic        hit_q;
  logic [3:0]  hit_step_q;

  logic signed [16:0] dx, dy;
  logic signed [33:0] dx_sq, dy_sq;
  logic [34:0]        d2_wide;
  logic [31:0]        d2;
  logic [31:0]        min_next;
  logic               new_hit;
  logic               hit_next;
  logic [3:0]         hit_step_next;
  logic               last_step;

  // p + (v >>> DT_SHIFT), clamped to the signed 16-bit range instead of wrapping.
  function automatic logic [15:0] sat_add(input logic [15:0] p, input logic [15:0] v);
    logic signed [16:0] pe;
    logic signed [16:0] ve;
    logic signed [16:0] s;
    pe = $signed({p[15], p});
    ve = $signed({v[15], v}) >>> DT_SHIFT;
    s  = pe + ve;
    if (s[16] != s[15]) begin
      sat_add = s[16] ? 16'h8000 : 16'h7FFF;
    end else begin
      sat_add = s[15:0];
    end
  endfunction

  assign rd_edge = read_done & ~read_done_q;
  assign busy    = (state_q != StIdle);

  always_comb begin
    dx            = $signed({p1x_q[15], p1x_q}) - $signed({p2x_q[15], p2x_q});
    dy            = $signed({p1y_q[15], p1y_q}) - $signed({p2y_q[15], p2y_q});
    dx_sq         = dx * dx;
    dy_sq         = dy * dy;
    d2_wide       = {1'b0, dx_sq} + {1'b0, dy_sq};
    d2            = (|d2_wide[34:32]) ? 32'hFFFF_FFFF : d2_wide[31:0];
    min_next      = (d2 < min_q) ? d2 : min_q;
    // Strict compare: a separation exactly at the threshold is not a collision.
    new_hit       = (d2 < SafeSq) && !hit_q;
    hit_next      = hit_q | new_hit;
    hit_step_next = new_hit ? step_q : hit_step_q;
    last_step     = (step_q == 4'(STEPS));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (rd_edge) state_d = StRun;
      StRun:   if (last_step) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      read_done_q  <= 1'b0;
      overrun      <= 1'b0;
      result_valid <= 1'b0;
      collision    <= 1'b0;
      hit_step     <= 4'd0;
      min_dist_sq  <= 32'hFFFF_FFFF;
      p1x_q        <= 16'h0000;
      p1y_q        <= 16'h0000;
      v1x_q        <= 16'h0000;
      v1y_q        <= 16'h0000;
      p2x_q        <= 16'h0000;
      p2y_q        <= 16'h0000;
      v2x_q        <= 16'h0000;
      v2y_q        <= 16'h0000;
      step_q       <= 4'd0;
      min_q        <= 32'hFFFF_FFFF;
      hit_q        <= 1'b0;
      hit_step_q   <= 4'd0;
    end else begin
      state_q      <= state_d;
      read_done_q  <= read_done;
      overrun      <= rd_edge && (state_q != StIdle);
      result_valid <= (state_q == StRun) && last_step;

      if ((state_q == StIdle) && rd_edge) begin
        p1x_q      <= x1_bin;
        p1y_q      <= y1_bin;
        v1x_q      <= vx1_bin;
        v1y_q      <= vy1_bin;
        p2x_q      <= x2_bin;
        p2y_q      <= y2_bin;
        v2x_q      <= vx2_bin;
        v2y_q      <= vy2_bin;
        step_q     <= 4'd0;
        min_q      <= 32'hFFFF_FFFF;
        hit_q      <= 1'b0;
        hit_step_q <= 4'd0;
      end else if (state_q == StRun) begin
        step_q     <= step_q + 4'd1;
        min_q      <= min_next;
        hit_q      <= hit_next;
        hit_step_q <= hit_step_next;
        p1x_q      <= sat_add(p1x_q, v1x_q);
        p1y_q      <= sat_add(p1y_q, v1y_q);
        p2x_q      <= sat_add(p2x_q, v2x_q);
        p2y_q      <= sat_add(p2y_q, v2y_q);
        // Final step's values go straight to the outputs so they are valid during DONE.
        if (last_step) begin
          collision   <= hit_next;
          hit_step    <= hit_step_next;
          min_dist_sq <= min_next;
        end
      end
    end
  end

endmodule
